// File: rtl/stopwatch_dp.sv
// -----------------------------------------------------------------------------
// stopwatch_dp -- stopwatch datapath (tick divider + binary time counters)
//
// Takes the run/stop and clear levels from the stopwatch control FSM. It
// produces the running time as plain binary counts (not BCD) for the display
// formatter.
//
// Parameters
//   CLK_FREQ  input clock frequency in Hz
//   TICK_HZ   centisecond count rate; DIV = CLK_FREQ/TICK_HZ, integer >= 2
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   i_runstop   level: 1 = count, 0 = hold (divider phase is preserved)
//   i_clear     level: 1 = zero divider and all counts (wins over i_runstop)
//   o_msec      centiseconds 0..99
//   o_sec       seconds      0..59
//   o_min       minutes      0..59
//   o_hour      hours        0..23
//   o_tick      one-clk pulse, coincident with each centisecond increment
//
// Optional feature, compiled in with `define LAP_CAPTURE_EN:
//   i_lap        one-clk lap request, honoured only while counting
//   o_lap_valid  set by a captured lap, cleared by rst / i_clear
//   o_lap_msec / o_lap_sec / o_lap_min / o_lap_hour
//                snapshot of the live counts as they stood before the
//                capturing edge
//
// All outputs are registered, so no input reaches a count combinationally.
// -----------------------------------------------------------------------------

// One wrapping counter digit group: counts 0..MAX on inc, and wraps to 0 after MAX.
// The top level derives the carry, so this block stays a plain register.
module stopwatch_dp_cnt #(
  parameter int W   = 7,
  parameter int MAX = 99
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      q <= '0;
    else if (inc)
      q <= (q == W'(MAX)) ? '0 : q + 1'b1;
  end

endmodule

module stopwatch_dp #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_runstop,
  input  logic       i_clear,
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
`ifdef LAP_CAPTURE_EN
  ,
  input  logic       i_lap,
  output logic       o_lap_valid,
  output logic [6:0] o_lap_msec,
  output logic [5:0] o_lap_sec,
  output logic [5:0] o_lap_min,
  output logic [4:0] o_lap_hour
`endif
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  // Reject a divider that is fractional or too short to produce a pulse.
  if (DIV < 2 || DIV * TICK_HZ != CLK_FREQ) begin : g_bad_div
    $error("stopwatch_dp: CLK_FREQ/TICK_HZ must be an integer >= 2");
  end

  // ---------------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_q;
  logic          run;
  logic          wrap;

  // Clear takes priority over run, so a simultaneous clear never ticks.
  assign run  = i_runstop && !i_clear;
  assign wrap = run && (div_q == DW'(DIV - 1));

  // While stopped, the divider simply holds. If run drops on the very edge
  // that would have wrapped, the divider stays parked at DIV-1, and the missing
  // tick fires on the first running edge after resume.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      div_q  <= '0;
      o_tick <= 1'b0;
    end else if (run) begin
      div_q  <= wrap ? '0 : div_q + 1'b1;
      o_tick <= wrap;
    end else begin
      o_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Counter chain. Each carry is decoded from the current (pre-edge) values.
  // A full 23:59:59.99 rollover therefore lands in a single edge.
  // ---------------------------------------------------------------------------
  logic c_msec;
  logic c_sec;
  logic c_min;

  assign c_msec = wrap   && (o_msec == 7'd99);
  assign c_sec  = c_msec && (o_sec  == 6'd59);
  assign c_min  = c_sec  && (o_min  == 6'd59);

  stopwatch_dp_cnt #(.W(7), .MAX(99)) u_msec (
    .clk (clk),
    .rst (rst),
    .clr (i_clear),
    .inc (wrap),
    .q   (o_msec)
  );

  stopwatch_dp_cnt #(.W(6), .MAX(59)) u_sec (
    .clk (clk),
    .rst (rst),
    .clr (i_clear),
    .inc (c_msec),
    .q   (o_sec)
  );

  stopwatch_dp_cnt #(.W(6), .MAX(59)) u_min (
    .clk (clk),
    .rst (rst),
    .clr (i_clear),
    .inc (c_sec),
    .q   (o_min)
  );

  stopwatch_dp_cnt #(.W(5), .MAX(23)) u_hour (
    .clk (clk),
    .rst (rst),
    .clr (i_clear),
    .inc (c_min),
    .q   (o_hour)
  );

`ifdef LAP_CAPTURE_EN
  // ---------------------------------------------------------------------------
  // Lap capture: snapshot the live registers as they stand before this edge.
  // Lap requests made while stopped or while clearing are dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      o_lap_valid <= 1'b0;
      o_lap_msec  <= '0;
      o_lap_sec   <= '0;
      o_lap_min   <= '0;
      o_lap_hour  <= '0;
    end else if (run && i_lap) begin
      o_lap_valid <= 1'b1;
      o_lap_msec  <= o_msec;
      o_lap_sec   <= o_sec;
      o_lap_min   <= o_min;
      o_lap_hour  <= o_hour;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_dp.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_dp -- self-checking bench for stopwatch_dp (CLK_FREQ=1000,
// TICK_HZ=100, so DIV=10).
//
// The reference model tracks only two numbers. The first is the count of
// running edges since the last clear/reset. The second is a preload offset in
// centiseconds. The expected time is (run_edges/DIV + offset) mod one day,
// split into h/m/s/cs by arithmetic. On every falling edge, a compare process
// checks the DUT against that model. Directed scenarios add literal
// expectations on top.
// -----------------------------------------------------------------------------
module tb_stopwatch_dp;

  localparam int CLK_FREQ = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = 10;
  localparam int DAY      = 24 * 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_runstop = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_lap = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;
`ifdef LAP_CAPTURE_EN
  logic       o_lap_valid;
  logic [6:0] o_lap_msec;
  logic [5:0] o_lap_sec;
  logic [5:0] o_lap_min;
  logic [4:0] o_lap_hour;
`endif

  stopwatch_dp #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_runstop (i_runstop),
    .i_clear   (i_clear),
    .o_msec    (o_msec),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_tick    (o_tick)
`ifdef LAP_CAPTURE_EN
    ,
    .i_lap       (i_lap),
    .o_lap_valid (o_lap_valid),
    .o_lap_msec  (o_lap_msec),
    .o_lap_sec   (o_lap_sec),
    .o_lap_min   (o_lap_min),
    .o_lap_hour  (o_lap_hour)
`endif
  );

  always #5 clk = ~clk;

  int n_err   = 0;
  int n_chk   = 0;
  int n_ticks = 0;
  bit chk_en  = 1'b0;

  // Reference model state
  int m_run   = 0;     // running edges since clear/reset
  int m_off   = 0;     // preload offset, centiseconds
  bit m_tick  = 1'b0;
  int m_lap   = 0;     // lap time, centiseconds
  bit m_lap_v = 1'b0;
  bit m_lap_seen = 1'b0; // i_lap was applied during random stimulus

  function automatic int exp_t();
    return (m_run / DIV + m_off) % DAY;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; the model samples them at
  // the next rising edge, just like the DUT does.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst || i_clear) begin
      m_run   <= 0;
      m_off   <= 0;
      m_tick  <= 1'b0;
      m_lap   <= 0;
      m_lap_v <= 1'b0;
    end else if (i_runstop) begin
      m_run  <= m_run + 1;
      m_tick <= ((m_run + 1) % DIV == 0);
      if (i_lap) begin
        m_lap   <= exp_t();
        m_lap_v <= 1'b1;
      end
    end else begin
      m_tick <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int t;
      t = exp_t();
      chk("msec", int'(o_msec), t % 100);
      chk("sec",  int'(o_sec),  (t / 100) % 60);
      chk("min",  int'(o_min),  (t / 6000) % 60);
      chk("hour", int'(o_hour), t / 360000);
      chk("tick", int'(o_tick), int'(m_tick));
`ifdef LAP_CAPTURE_EN
      chk("lap_valid", int'(o_lap_valid), int'(m_lap_v));
      chk("lap_msec",  int'(o_lap_msec),  m_lap % 100);
      chk("lap_sec",   int'(o_lap_sec),   (m_lap / 100) % 60);
      chk("lap_min",   int'(o_lap_min),   (m_lap / 6000) % 60);
      chk("lap_hour",  int'(o_lap_hour),  m_lap / 360000);
`endif
      if (o_tick) n_ticks++;
    end
  end

  initial begin
    int k;

    // Reset
    rst = 1'b1;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_msec", int'(o_msec), 0);
    chk("rst_hour", int'(o_hour), 0);
    chk("rst_tick", int'(o_tick), 0);

    // 100 running clocks -> exactly 10 ticks, 00:00:00.10
    n_ticks = 0;
    i_runstop = 1'b1;
    step(100);
    i_runstop = 1'b0;
    @(negedge clk); #1;
    chk("run100_ticks", n_ticks, 10);
    chk("run100_msec", int'(o_msec), 10);
    chk("run100_sec", int'(o_sec), 0);

    // Run 5, pause 50, resume: the next tick arrives 5 clocks after resume
    i_runstop = 1'b1;
    step(5);
    i_runstop = 1'b0;
    step(50);
    chk("pause_msec", int'(o_msec), 10);
    i_runstop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk("resume_tick", int'(o_tick), (i == 5) ? 1 : 0);
    end
    chk("resume_msec", int'(o_msec), 11);

    // Stop exactly on the would-wrap edge: divider parks at DIV-1 with no tick
    step(9);
    i_runstop = 1'b0;
    step(3);
    chk("park_tick", int'(o_tick), 0);
    chk("park_msec", int'(o_msec), 11);
    i_runstop = 1'b1;
    step(1);
    chk("park_resume_tick", int'(o_tick), 1);
    chk("park_resume_msec", int'(o_msec), 12);

    // Randomised run/stop/clear/reset/lap traffic
    for (int i = 0; i < 400; i++) begin
      i_runstop = ($urandom_range(0, 3) != 0);
      i_clear   = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      i_lap     = ($urandom_range(0, 19) == 0);
      if (i_lap) m_lap_seen = 1'b1;
      step(1);
    end
    rst = 1'b0; i_clear = 1'b0; i_lap = 1'b0; i_runstop = 1'b0;

    // Full-day rollover: preload 23:59:59.99 while stopped, then run one tick
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    force dut.u_msec.q = 7'd99;
    force dut.u_sec.q  = 6'd59;
    force dut.u_min.q  = 6'd59;
    force dut.u_hour.q = 5'd23;
    m_off = DAY - 1;
    step(1);
    release dut.u_msec.q;
    release dut.u_sec.q;
    release dut.u_min.q;
    release dut.u_hour.q;
    step(1);
    chk("preload_hour", int'(o_hour), 23);
    chk("preload_msec", int'(o_msec), 99);
    i_runstop = 1'b1;
    step(DIV - 1);
    chk("prewrap_tick", int'(o_tick), 0);
    chk("prewrap_min", int'(o_min), 59);
    step(1);
    chk("wrap_tick", int'(o_tick), 1);
    chk("wrap_msec", int'(o_msec), 0);
    chk("wrap_sec", int'(o_sec), 0);
    chk("wrap_min", int'(o_min), 0);
    chk("wrap_hour", int'(o_hour), 0);

    // Clear wins over run; counts and divider held at zero while asserted
    for (k = 0; k < 600 && o_msec != 7'd37; k++) step(1);
    chk("reach_msec37", int'(o_msec), 37);
    i_clear = 1'b1;
    step(1);
    chk("clear_msec", int'(o_msec), 0);
    chk("clear_tick", int'(o_tick), 0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("clear_hold_tick", int'(o_tick), 0);
    end
    i_clear = 1'b0;
    step(DIV - 1);
    chk("post_clear_notick", int'(o_tick), 0);
    step(1);
    chk("post_clear_tick", int'(o_tick), 1);
    chk("post_clear_msec", int'(o_msec), 1);

    // Reset mid-count at 00:00:12.50
    for (k = 0; k < 20000 && !(o_sec == 6'd12 && o_msec == 7'd50); k++) step(1);
    chk("reach_sec12", int'(o_sec), 12);
    chk("reach_msec50", int'(o_msec), 50);
    rst = 1'b1;
    step(1);
    chk("midrst_sec", int'(o_sec), 0);
    chk("midrst_msec", int'(o_msec), 0);
    rst = 1'b0;
    step(DIV - 1);
    chk("post_rst_notick", int'(o_tick), 0);
    step(1);
    chk("post_rst_tick", int'(o_tick), 1);
    chk("post_rst_msec", int'(o_msec), 1);

`ifdef LAP_CAPTURE_EN
    // Lap at 00:00:01.23 captures pre-edge counts; live count continues
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    for (k = 0; k < 2000 && !(o_sec == 6'd1 && o_msec == 7'd23); k++) step(1);
    i_lap = 1'b1;
    step(1);
    i_lap = 1'b0;
    chk("lap_lit_valid", int'(o_lap_valid), 1);
    chk("lap_lit_sec", int'(o_lap_sec), 1);
    chk("lap_lit_msec", int'(o_lap_msec), 23);
    chk("lap_lit_min", int'(o_lap_min), 0);
    step(2 * DIV);
    chk("lap_live_msec", int'(o_msec), 25);
    chk("lap_hold_msec", int'(o_lap_msec), 23);
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
    chk("lap_clear_valid", int'(o_lap_valid), 0);
    i_runstop = 1'b0;
    i_lap = 1'b1;
    step(1);
    i_lap = 1'b0;
    chk("lap_stopped_valid", int'(o_lap_valid), 0);
`endif

    i_runstop = 1'b0;
    step(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
